ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Purpose: shares one single-port RAM request port between the core instruction-fetch requester (I) and the data-bus requester (D), using req/gnt/rvalid handshakes.

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32, meaning address width.
REQ-002 The block SHALL have parameter DataWidth, default 32, meaning data width.
REQ-003 The block SHALL have parameter StarveLimit, default 4, meaning the maximum number of consecutive D grants while I is pending (legal range 1..15).
REQ-004 The block SHALL have these ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  reset; asynchronous, active-high.
- i_req_i  in  1  instruction-fetch request.
- i_addr_i  in  AddrWidth  fetch byte address.
- i_gnt_o  out  1  fetch request accepted this cycle.
- i_rvalid_o  out  1  fetch response valid.
- i_rdata_o  out  DataWidth  fetch response data.
- d_req_i  in  1  data request.
- d_we_i  in  1  data write enable.
- d_be_i  in  DataWidth/8  data byte enables.
- d_addr_i  in  AddrWidth  data byte address.
- d_wdata_i  in  DataWidth  data write data.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  data response valid (reads and writes).
- d_rdata_o  out  DataWidth  data response data.
- m_req_o  out  1  RAM request.
- m_we_o  out  1  RAM write enable.
- m_be_o  out  DataWidth/8  RAM byte enables.
- m_addr_o  out  AddrWidth  RAM address.
- m_wdata_o  out  DataWidth  RAM write data.
- m_rvalid_i  in  1  RAM response valid.
- m_rdata_i  in  DataWidth  RAM response data.
- spurious_o  out  1  sticky flag: a RAM response arrived with nothing outstanding.

Function
REQ-005 Grant SHALL be combinational and SHALL occur in the same cycle as the request; m_req_o = i_gnt_o | d_gnt_o; at most one grant per cycle.
REQ-006 A grant SHALL be allowed only when the outstanding-tag FIFO (depth 2) holds fewer than 2 entries; otherwise both gnt outputs SHALL be 0 and the requesters hold their requests.
REQ-007 Default priority SHALL go to D; I SHALL be granted when d_req_i=0, or when starve_cnt == StarveLimit.
REQ-008 starve_cnt (4 bits) SHALL increment on each D grant while i_req_i=1, SHALL clear on an I grant or in any cycle with i_req_i=0, and SHALL saturate at StarveLimit.
REQ-009 On an I grant: m_addr_o=i_addr_i, m_we_o=0, m_be_o=all ones, m_wdata_o=0.
REQ-010 On a D grant: m_we/be/addr/wdata SHALL equal the corresponding d_* inputs.
REQ-011 With no grant, m_we_o SHALL be 0 and the other m_* fields are don't-care.
REQ-012 Each grant SHALL push an owner tag (0=I, 1=D) into the FIFO at the clock edge.
REQ-013 Each m_rvalid_i SHALL pop the head tag and route the response combinationally (zero added latency) to i_rvalid_o/i_rdata_o or d_rvalid_o/d_rdata_o.
REQ-014 The rvalid output of the non-owner SHALL be 0; rdata of a non-valid port is don't-care.
REQ-015 A push and a pop in the same cycle SHALL leave the count unchanged and preserve response order.
REQ-016 m_rvalid_i with an empty FIFO SHALL produce no rvalid output, SHALL leave the FIFO unchanged, and SHALL set spurious_o, which stays set until reset.
REQ-017 Responses SHALL be returned in grant order; the RAM is in-order with latency of 1 or more cycles.

Reset
REQ-018 While RST=1 (asynchronous): FIFO emptied, starve_cnt=0, spurious_o=0, i_gnt_o=d_gnt_o=m_req_o=0, i_rvalid_o=d_rvalid_o=0.
REQ-019 Responses outstanding when reset is asserted SHALL be discarded, and later m_rvalid_i for them SHALL set spurious_o.
REQ-020 The first grant SHALL be possible in the first cycle after RST deasserts.

Verification
REQ-021 I-only: i_req at 0x00100000, RAM latency 1 -> i_gnt same cycle, i_rvalid next cycle with m_rdata; d_rvalid stays 0.
REQ-022 Contention with StarveLimit=4: i_req and d_req held high for 10 cycles -> grant pattern D,D,D,D,I,D,D,D,D,I.
REQ-023 D write (be=0011, wdata=0xDEADBEEF) -> m_we=1, m_be=0011, m_wdata=0xDEADBEEF; d_rvalid asserted one cycle later.
REQ-024 RAM latency 2 with back-to-back I,D,I requests -> FIFO full, third request stalled one cycle; responses routed I,D,I in order.
REQ-025 m_rvalid_i pulsed with nothing outstanding -> no rvalid output, spurious_o=1 until RST.
REQ-026 RST asserted with one response outstanding -> outputs zero immediately; after release, the stale m_rvalid_i sets spurious_o and is not routed.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one in-order single-port RAM between the fetch (I)
// and data (D) requesters. Grants are combinational. D wins by default, and a
// starvation counter forces an I grant after StarveLimit consecutive D grants.
// A two-deep tag FIFO remembers who owns each outstanding access. Responses
// are steered back to that owner with no added latency.
module ram_port_arbiter #(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32,
  parameter int StarveLimit = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  // instruction-fetch requester
  input  logic                   i_req_i,
  input  logic [AddrWidth-1:0]   i_addr_i,
  output logic                   i_gnt_o,
  output logic                   i_rvalid_o,
  output logic [DataWidth-1:0]   i_rdata_o,
  // data requester
  input  logic                   d_req_i,
  input  logic                   d_we_i,
  input  logic [DataWidth/8-1:0] d_be_i,
  input  logic [AddrWidth-1:0]   d_addr_i,
  input  logic [DataWidth-1:0]   d_wdata_i,
  output logic                   d_gnt_o,
  output logic                   d_rvalid_o,
  output logic [DataWidth-1:0]   d_rdata_o,
  // shared RAM port
  output logic                   m_req_o,
  output logic                   m_we_o,
  output logic [DataWidth/8-1:0] m_be_o,
  output logic [AddrWidth-1:0]   m_addr_o,
  output logic [DataWidth-1:0]   m_wdata_o,
  input  logic                   m_rvalid_i,
  input  logic [DataWidth-1:0]   m_rdata_i,
  output logic                   spurious_o
);

  localparam int          BeWidth  = DataWidth / 8;
  localparam logic [3:0]  LimitVal = 4'(StarveLimit);

  // Owner tags of outstanding accesses: 0 = I, 1 = D.
  logic [1:0] r_tagFifo;
  logic       r_wrPtr;
  logic       r_rdPtr;
  logic [1:0] r_count;
  logic [3:0] r_starveCnt;
  logic       r_spurious;

  logic w_full;
  logic w_empty;
  logic w_iWins;
  logic w_iGnt;
  logic w_dGnt;
  logic w_push;
  logic w_pop;
  logic w_stray;
  logic w_headTag;

  assign w_full    = (r_count == 2'd2);
  assign w_empty   = (r_count == 2'd0);
  assign w_headTag = r_tagFifo[r_rdPtr];

  // I wins when D is idle or when D has starved I for StarveLimit grants.
  always_comb begin
    w_iWins = i_req_i && (!d_req_i || (r_starveCnt == LimitVal));
    w_iGnt  = 1'b0;
    w_dGnt  = 1'b0;
    if (!RST && !w_full) begin
      w_iGnt = w_iWins;
      w_dGnt = d_req_i && !w_iWins;
    end
  end

  assign w_push  = w_iGnt | w_dGnt;
  assign w_pop   = m_rvalid_i & ~w_empty;
  assign w_stray = m_rvalid_i & w_empty;

  assign i_gnt_o = w_iGnt;
  assign d_gnt_o = w_dGnt;
  assign m_req_o = w_push;

  // Drive the RAM request fields from whichever requester holds the grant.
  always_comb begin
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (w_iGnt) begin
      m_we_o    = 1'b0;
      m_be_o    = {BeWidth{1'b1}};
      m_addr_o  = i_addr_i;
      m_wdata_o = '0;
    end else if (w_dGnt) begin
      m_we_o    = d_we_i;
      m_be_o    = d_be_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
    end
  end

  // Steer each response to the owner recorded at the head of the tag FIFO.
  assign i_rvalid_o = w_pop & ~w_headTag;
  assign d_rvalid_o = w_pop &  w_headTag;
  assign i_rdata_o  = m_rdata_i;
  assign d_rdata_o  = m_rdata_i;
  assign spurious_o = r_spurious;

  // Tag FIFO: push the owner on each grant and pop on each matched response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tagFifo <= '0;
      r_wrPtr   <= 1'b0;
      r_rdPtr   <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_tagFifo[r_wrPtr] <= w_dGnt;
        r_wrPtr            <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Count D grants that bypass a waiting I; any I grant or idle I clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_starveCnt <= 4'd0;
    end else if (!i_req_i || w_iGnt) begin
      r_starveCnt <= 4'd0;
    end else if (w_dGnt && (r_starveCnt != LimitVal)) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

  // A response with nothing outstanding latches the sticky spurious flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_spurious <= 1'b0;
    end else if (w_stray) begin
      r_spurious <= 1'b1;
    end
  end

endmodule
